rr_arbiter4: RTL and testbench

Round-robin, burst-limited arbiter that drives the 2-bit select of the 4-input, 4-bit-wide mux datapath. It takes one request per mux input channel and grants exactly one channel at a time. It holds the grant stable until the downstream consumer accepts, then rotates priority. It sits directly upstream of the mux: `sel` feeds the mux select, and `valid` qualifies the mux output to the consumer.

---
 rtl/rr_arbiter4_pkg.sv | 20 ++
 rtl/rr_arbiter4_pick.sv | 37 +++
 rtl/rr_arbiter4.sv | 117 +++++++++++
 tb/tb_rr_arbiter4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared constants, state encoding and index helpers for the 4-channel
// round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: first requesting channel at or after ptr,
// wrapping modulo 4.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  // w_rot[k] is the request of the channel k positions after ptr
  logic [NUM_CH-1:0] w_rot;
  logic [SEL_W-1:0]  w_off;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      logic [SEL_W-1:0] w_ch;
      assign w_ch      = ptr + SEL_W'(gi);
      assign w_rot[gi] = req[w_ch];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = k[SEL_W-1:0];
      end
    end
  end

  assign idx = ptr + w_off;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Burst-limited round-robin arbiter driving the select of a 4:1 mux; grant is
// held until the consumer accepts, then priority rotates past the winner.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int BURST = 1,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  localparam logic [CNT_W:0] BURST_L = BURST[CNT_W:0];

  state_t            r_state, w_state_next;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_next;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_next;
  logic [SEL_W-1:0]  r_sel,   w_sel_next;
  logic [NUM_CH-1:0] r_grant, w_grant_next;
  logic              r_valid, w_valid_next;

  logic [SEL_W-1:0]  w_pick_ptr;
  logic [SEL_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_hs;
  logic              w_req_sel;
  logic [CNT_W:0]    w_cnt_inc;
  logic              w_more;

  // In GRANT the only re-pick ever needed is after rotating past the current
  // owner, so the shared picker can be fed sel+1 directly.
  assign w_pick_ptr = (r_state == ST_GRANT) ? (r_sel + 1'b1) : r_ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_hs      = r_valid & ready;
  assign w_req_sel = req[r_sel];
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_more    = (w_cnt_inc < BURST_L);

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_sel_next   = r_sel;
    w_grant_next = r_grant;
    w_valid_next = r_valid;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_next = ST_GRANT;
          w_sel_next   = w_pick_idx;
          w_grant_next = to_onehot(w_pick_idx);
          w_valid_next = 1'b1;
          w_cnt_next   = '0;
        end
      end
      ST_GRANT: begin
        if (w_hs && w_req_sel && w_more) begin
          w_cnt_next = w_cnt_inc[CNT_W-1:0];
        end else if (w_hs || !w_req_sel) begin
          w_ptr_next = r_sel + 1'b1;
          w_cnt_next = '0;
          if (w_pick_any) begin
            w_sel_next   = w_pick_idx;
            w_grant_next = to_onehot(w_pick_idx);
            w_valid_next = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_grant_next = '0;
            w_valid_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
        w_valid_next = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_sel   <= w_sel_next;
      r_grant <= w_grant_next;
      r_valid <= w_valid_next;
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized checks of rr_arbiter4 (BURST=1 and BURST=3 copies
// on shared inputs) against a behavioural round-robin model.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic [1:0] dut_sel   [2];
  logic [3:0] dut_grant [2];
  logic       dut_valid [2];

  int checks = 0;
  int errors = 0;

  // model state per DUT: index 0 is BURST=1, index 1 is BURST=3
  int m_burst [2] = '{1, 3};
  int m_valid [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_beats [2];

  rr_arbiter4 #(.BURST(1), .CNT_W(4)) u_dut_b1 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(dut_sel[0]), .grant(dut_grant[0]), .valid(dut_valid[0])
  );

  rr_arbiter4 #(.BURST(3), .CNT_W(4)) u_dut_b3 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(dut_sel[1]), .grant(dut_grant[1]), .valid(dut_valid[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int off = 0; off < 4; off++) begin
      int ch;
      ch = (start + off) % 4;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_beats[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    int p;
    if (m_valid[d] == 0) begin
      p = pick(req, m_ptr[d]);
      if (p >= 0) begin
        m_valid[d] = 1; m_sel[d] = p; m_beats[d] = 0;
      end
    end else begin
      if (ready && req[m_sel[d]] && (m_beats[d] + 1 < m_burst[d])) begin
        m_beats[d]++;
      end else if (ready || !req[m_sel[d]]) begin
        m_ptr[d] = (m_sel[d] + 1) % 4;
        p = pick(req, m_ptr[d]);
        m_beats[d] = 0;
        if (p >= 0) m_sel[d] = p;
        else        m_valid[d] = 0;
      end
    end
  endtask

  task automatic compare_model(input string ctx);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.dut%0d.valid", ctx, d), 8'(dut_valid[d]), 8'(m_valid[d]));
      chk($sformatf("%s.dut%0d.sel", ctx, d), 8'(dut_sel[d]), 8'(m_sel[d]));
      chk($sformatf("%s.dut%0d.grant", ctx, d), 8'(dut_grant[d]),
          m_valid[d] != 0 ? 8'(1 << m_sel[d]) : 8'd0);
    end
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    $display("t=%0t %s req=%b ready=%b | b1 v=%0b s=%0d g=%b | b3 v=%0b s=%0d g=%b",
             $time, ctx, req, ready, dut_valid[0], dut_sel[0], dut_grant[0],
             dut_valid[1], dut_sel[1], dut_grant[1]);
    compare_model(ctx);
  endtask

  // async pulse landing between edges; outputs must clear before any edge
  task automatic async_reset(input string ctx);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.rst.dut%0d.valid", ctx, d), 8'(dut_valid[d]), 8'd0);
      chk($sformatf("%s.rst.dut%0d.grant", ctx, d), 8'(dut_grant[d]), 8'd0);
      chk($sformatf("%s.rst.dut%0d.sel", ctx, d), 8'(dut_sel[d]), 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq_rot [6] = '{0, 1, 2, 3, 0, 1};
    int seq_bst [7] = '{0, 0, 0, 1, 1, 1, 0};

    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    model_reset();
    #2;
    chk("reset.valid", 8'(dut_valid[0]), 8'd0);
    chk("reset.grant", 8'(dut_grant[0]), 8'd0);
    chk("reset.sel", 8'(dut_sel[1]), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // single request from IDLE, held with ready low
    req = 4'b0001; ready = 1'b0;
    step("single");
    chk("single.valid", 8'(dut_valid[0]), 8'd1);
    chk("single.sel", 8'(dut_sel[0]), 8'd0);
    chk("single.grant", 8'(dut_grant[0]), 8'b0001);
    for (int i = 0; i < 5; i++) begin
      step("single.hold");
      chk($sformatf("single.hold%0d.grant", i), 8'(dut_grant[0]), 8'b0001);
    end

    // full rotation on BURST=1
    async_reset("rot");
    req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rot");
      chk($sformatf("rot%0d.sel", i), 8'(dut_sel[0]), 8'(seq_rot[i]));
      chk($sformatf("rot%0d.valid", i), 8'(dut_valid[0]), 8'd1);
    end

    // burst limit on BURST=3
    async_reset("burst");
    req = 4'b0011; ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step("burst");
      chk($sformatf("burst%0d.sel", i), 8'(dut_sel[1]), 8'(seq_bst[i]));
    end

    // drop without handshake on channel 3, ptr wraps to 0
    async_reset("drop");
    req = 4'b1000; ready = 1'b0;
    step("drop.grant3");
    chk("drop.grant3.sel", 8'(dut_sel[0]), 8'd3);
    req = 4'b1001;
    step("drop.hold");
    chk("drop.hold.sel", 8'(dut_sel[0]), 8'd3);
    req = 4'b0001;
    step("drop.wrap");
    chk("drop.wrap.sel", 8'(dut_sel[0]), 8'd0);
    chk("drop.wrap.grant", 8'(dut_grant[0]), 8'b0001);
    req = 4'b0000;
    step("drop.idle");
    chk("drop.idle.valid", 8'(dut_valid[0]), 8'd0);
    chk("drop.idle.grant", 8'(dut_grant[0]), 8'd0);
    step("drop.idle2");
    chk("drop.idle2.valid", 8'(dut_valid[1]), 8'd0);

    // async reset mid-grant on channel 2, then re-request channel 3
    async_reset("mid.pre");
    req = 4'b0100; ready = 1'b0;
    step("mid.grant2");
    chk("mid.grant2.sel", 8'(dut_sel[0]), 8'd2);
    chk("mid.grant2.valid", 8'(dut_valid[0]), 8'd1);
    async_reset("mid");
    req = 4'b1000;
    step("mid.after");
    chk("mid.after.sel", 8'(dut_sel[0]), 8'd3);
    chk("mid.after.valid", 8'(dut_valid[0]), 8'd1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand");
      end else begin
        if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
        ready = 1'($urandom_range(0, 1));
        step("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
